// File: rtl/mge_link_rst_pkg.sv
// Shared types and constants for the MGE link reset sequencer.
package mge_link_rst_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        ST_PULSE    = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAIL     = 3'd4
    } seq_state_e;

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/mge_link_rst_timer.sv
// Clear/enable up-counter that stops at CYC-1 and flags the terminal count.
module mge_link_rst_timer #(
    parameter int unsigned CYC = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned W  = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [W-1:0] TC = W'(CYC - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/mge_link_reset_sequencer.sv
// Transceiver channel reset / MAC reset release sequencer with timeout and retry.
// Define MGE_LINK_LOCK_MONITOR_EN to restart the link on sustained CDR lock loss in RUN.
//
// state    | meaning
// PULSE    | xcvr_rst_req asserted for RST_PULSE_CYC non-busy cycles
// WAIT_RDY | waiting for tx_ready & rx_ready, timeout running
// SETTLE   | both readies must hold for SETTLE_CYC cycles
// RUN      | MAC resets released, link_up
// FAIL     | retries exhausted, parked until reconfig_req or reset
module mge_link_reset_sequencer
    import mge_link_rst_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC     = 32,
    parameter int unsigned READY_TIMEOUT_CYC = 1000000,
    parameter int unsigned SETTLE_CYC        = 16,
    parameter int unsigned LOCK_DEBOUNCE_CYC = 64,
    parameter int unsigned MAX_RETRY         = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_reconfig_req,
    input  logic               i_reconfig_busy,
    input  logic               i_tx_ready,
    input  logic               i_rx_ready,
    input  logic               i_rx_is_lockedtodata,
    output logic               o_xcvr_rst_req,
    output logic               o_mac_tx_reset,
    output logic               o_mac_rx_reset,
    output logic               o_link_up,
    output logic               o_timeout_err,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [2:0]         o_seq_state
);

    seq_state_e         r_state;
    seq_state_e         w_state_next;
    logic               r_xcvr_rst_req;
    logic               r_mac_reset;
    logic               r_link_up;
    logic               r_timeout_err;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               w_xcvr_rst_req;
    logic               w_mac_reset;
    logic               w_link_up;
    logic               w_both_ready;
    logic               w_pulse_tc;
    logic               w_to_tc;
    logic               w_settle_tc;
    logic               w_timeout;
    logic               w_lock_loss;
    logic               w_retry_exhausted;

    assign w_both_ready = i_tx_ready & i_rx_ready;
    assign w_retry_inc  = sat_inc(r_retry_cnt);
    assign w_retry_exhausted = (MAX_RETRY != 0) && (32'(w_retry_inc) >= MAX_RETRY);

    mge_link_rst_timer #(.CYC(RST_PULSE_CYC)) u_pulse_tmr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   ((r_state != ST_PULSE) || i_reconfig_req),
        .i_en    ((r_state == ST_PULSE) && !i_reconfig_busy),
        .o_tc    (w_pulse_tc)
    );

    mge_link_rst_timer #(.CYC(READY_TIMEOUT_CYC)) u_timeout_tmr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   ((r_state != ST_WAIT_RDY) || i_reconfig_req),
        .i_en    (r_state == ST_WAIT_RDY),
        .o_tc    (w_to_tc)
    );

    mge_link_rst_timer #(.CYC(SETTLE_CYC)) u_settle_tmr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   ((r_state != ST_SETTLE) || i_reconfig_req),
        .i_en    (r_state == ST_SETTLE),
        .o_tc    (w_settle_tc)
    );

`ifdef MGE_LINK_LOCK_MONITOR_EN
    logic w_dbn_tc;

    mge_link_rst_timer #(.CYC(LOCK_DEBOUNCE_CYC)) u_lock_dbn_tmr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   ((r_state != ST_RUN) || i_rx_is_lockedtodata || i_reconfig_req),
        .i_en    ((r_state == ST_RUN) && !i_rx_is_lockedtodata),
        .o_tc    (w_dbn_tc)
    );

    assign w_lock_loss = (r_state == ST_RUN) && !i_rx_is_lockedtodata && w_dbn_tc
                         && !i_reconfig_req;
`else
    logic [1:0] w_unused_lock;
    assign w_unused_lock = {i_rx_is_lockedtodata, (LOCK_DEBOUNCE_CYC == 0)};
    assign w_lock_loss   = 1'b0;
`endif

    // A ready pair arriving in the timeout cycle wins over the timeout.
    assign w_timeout = (r_state == ST_WAIT_RDY) && w_to_tc && !w_both_ready && !i_reconfig_req;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_PULSE;
            r_xcvr_rst_req <= 1'b1;
            r_mac_reset    <= 1'b1;
            r_link_up      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_xcvr_rst_req <= w_xcvr_rst_req;
            r_mac_reset    <= w_mac_reset;
            r_link_up      <= w_link_up;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_reconfig_req) begin
            w_state_next = ST_PULSE;
        end else if (w_lock_loss) begin
            w_state_next = ST_PULSE;
        end else begin
            case (r_state)
                ST_PULSE: begin
                    if (w_pulse_tc && !i_reconfig_busy) w_state_next = ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (w_both_ready)   w_state_next = ST_SETTLE;
                    else if (w_timeout) w_state_next = w_retry_exhausted ? ST_FAIL : ST_PULSE;
                end
                ST_SETTLE: begin
                    if (!w_both_ready)    w_state_next = ST_WAIT_RDY;
                    else if (w_settle_tc) w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!w_both_ready) w_state_next = ST_WAIT_RDY;
                end
                ST_FAIL: w_state_next = ST_FAIL;
                default: w_state_next = ST_PULSE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered with it.
    always_comb begin
        w_xcvr_rst_req = 1'b1;
        w_mac_reset    = 1'b1;
        w_link_up      = 1'b0;
        case (w_state_next)
            ST_WAIT_RDY, ST_SETTLE: begin
                w_xcvr_rst_req = 1'b0;
            end
            ST_RUN: begin
                w_xcvr_rst_req = 1'b0;
                w_mac_reset    = 1'b0;
                w_link_up      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_reconfig_req) begin
            r_timeout_err <= 1'b0;
            r_retry_cnt   <= '0;
        end else begin
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_timeout || w_lock_loss) r_retry_cnt <= w_retry_inc;
        end
    end

    assign o_xcvr_rst_req = r_xcvr_rst_req;
    assign o_mac_tx_reset = r_mac_reset;
    assign o_mac_rx_reset = r_mac_reset;
    assign o_link_up      = r_link_up;
    assign o_timeout_err  = r_timeout_err;
    assign o_retry_cnt    = r_retry_cnt;
    assign o_seq_state    = r_state;

endmodule
